// File: rtl/dice_game_ctrl.sv
// Dice-game round sequencer: spins two free-running dice counters, latches them on
// button release, scores doubles and tracks rolls remaining until a win or a loss.
module dice_game_ctrl #(
    parameter int WIN_SCORE = 3,
    parameter int MAX_ROLLS = 9
) (
    input  logic       sig,
    input  logic       rst,
    input  logic       roll,
    output logic [2:0] die_a,
    output logic [2:0] die_b,
    output logic       match,
    output logic [3:0] score,
    output logic [3:0] rolls_left,
    output logic       win,
    output logic       lose,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROLLING,
        S_CHECK,
        S_RESULT,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [3:0] WIN_C = 4'(WIN_SCORE);
    localparam logic [3:0] MAX_C = 4'(MAX_ROLLS);

    state_t     state_q, state_d;
    logic [2:0] cnt_a_q, cnt_a_d;
    logic [2:0] cnt_b_q, cnt_b_d;
    logic [2:0] die_a_q, die_a_d;
    logic [2:0] die_b_q, die_b_d;
    logic       roll_q;
    logic       match_q, match_d;
    logic [3:0] score_q, score_d;
    logic [3:0] rolls_left_q, rolls_left_d;
    logic       win_q, win_d;
    logic       lose_q, lose_d;
    logic       rise;
    logic       is_double;

    assign rise      = roll & ~roll_q;
    assign is_double = (die_a_q == die_b_q);

    // Odometer-style spin: B advances only when A wraps, so 36 edges visit every pair.
    always_comb begin
        cnt_a_d = (cnt_a_q == 3'd6) ? 3'd1 : cnt_a_q + 3'd1;
        cnt_b_d = cnt_b_q;
        if (cnt_a_q == 3'd6) begin
            cnt_b_d = (cnt_b_q == 3'd6) ? 3'd1 : cnt_b_q + 3'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        die_a_d      = die_a_q;
        die_b_d      = die_b_q;
        match_d      = match_q;
        score_d      = score_q;
        rolls_left_d = rolls_left_q;
        win_d        = win_q;
        lose_d       = lose_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    match_d = 1'b0;
                    state_d = S_ROLLING;
                end
            end
            S_ROLLING: begin
                // Live display; the load on the release edge is the one that sticks.
                die_a_d = cnt_a_q;
                die_b_d = cnt_b_q;
                if (!roll) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                match_d = is_double;
                if (is_double && (score_q < WIN_C)) begin
                    score_d = score_q + 4'd1;
                end
                if (rolls_left_q != 4'd0) begin
                    rolls_left_d = rolls_left_q - 4'd1;
                end
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (score_q == WIN_C) begin
                    win_d   = 1'b1;
                    state_d = S_WIN;
                end else if (rolls_left_q == 4'd0) begin
                    lose_d  = 1'b1;
                    state_d = S_LOSE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WIN, S_LOSE: begin
                if (rise) begin
                    score_d      = 4'd0;
                    rolls_left_d = MAX_C;
                    win_d        = 1'b0;
                    lose_d       = 1'b0;
                    match_d      = 1'b0;
                    state_d      = S_ROLLING;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sig or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_a_q      <= 3'd1;
            cnt_b_q      <= 3'd1;
            roll_q       <= 1'b0;
            die_a_q      <= 3'd1;
            die_b_q      <= 3'd1;
            match_q      <= 1'b0;
            score_q      <= 4'd0;
            rolls_left_q <= MAX_C;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            roll_q       <= roll;
            die_a_q      <= die_a_d;
            die_b_q      <= die_b_d;
            match_q      <= match_d;
            score_q      <= score_d;
            rolls_left_q <= rolls_left_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
        end
    end

    assign die_a      = die_a_q;
    assign die_b      = die_b_q;
    assign match      = match_q;
    assign score      = score_q;
    assign rolls_left = rolls_left_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign busy       = (state_q == S_ROLLING) || (state_q == S_CHECK) || (state_q == S_RESULT);

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Scoreboard bench for dice_game_ctrl: default instance plus a MAX_ROLLS=2 instance
// sharing clock, reset and the roll button.
module tb_dice_game_ctrl;

    logic       sig = 1'b0;
    logic       rst = 1'b1;
    logic       roll = 1'b0;
    logic [2:0] die_a, die_b, die_a2, die_b2;
    logic       match, win, lose, busy, match2, win2, lose2, busy2;
    logic [3:0] score, rolls_left, score2, rolls_left2;

    dice_game_ctrl dut (
        .sig(sig), .rst(rst), .roll(roll),
        .die_a(die_a), .die_b(die_b), .match(match), .score(score),
        .rolls_left(rolls_left), .win(win), .lose(lose), .busy(busy)
    );

    dice_game_ctrl #(.WIN_SCORE(3), .MAX_ROLLS(2)) dut2 (
        .sig(sig), .rst(rst), .roll(roll),
        .die_a(die_a2), .die_b(die_b2), .match(match2), .score(score2),
        .rolls_left(rolls_left2), .win(win2), .lose(lose2), .busy(busy2)
    );

    always #5 sig = ~sig;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       m;
        logic [3:0] s;
        logic [3:0] r;
        logic       w;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edges = 0;
    int   m_score = 0;
    int   m_rolls = 0;

    logic [2:0] oa, ob;
    logic       om, ow, ol, obusy;
    logic [3:0] os, orl;

    task tick();
        @(posedge sig);
        if (!rst) edges++;
        #1;
    endtask

    task sample(input bit two);
        if (two) begin
            oa = die_a2; ob = die_b2; om = match2; os = score2; orl = rolls_left2;
            ow = win2; ol = lose2; obusy = busy2;
        end else begin
            oa = die_a; ob = die_b; om = match; os = score; orl = rolls_left;
            ow = win; ol = lose; obusy = busy;
        end
    endtask

    task do_reset(input int rolls_init);
        rst = 1'b1;
        roll = 1'b0;
        tick(); tick();
        rst = 1'b0;
        edges = 0;
        m_score = 0;
        m_rolls = rolls_init;
    endtask

    // want: 0 = release after exactly hold edges, 1 = release on a double, 2 = on a non-double.
    // pulse: 1 = press during CHECK, 2 = press during RESULT (both must be ignored).
    task do_roll(input bit two, input int want, input int hold, input int pulse);
        exp_t e;
        int   h;
        bit   ok;
        bit   dbl;
        roll = 1'b1;
        tick();
        h = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            dbl = ((edges % 6) == ((edges / 6) % 6));
            if (h >= hold && (want == 0 || (want == 1 && dbl) || (want == 2 && !dbl))) begin
                ok = 1'b1;
                break;
            end
            tick();
            h++;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL roll_search: no suitable release point within budget (edges=%0d)", edges);
        end
        e.a = 3'((edges % 6) + 1);
        e.b = 3'(((edges / 6) % 6) + 1);
        e.m = (e.a == e.b);
        if (e.m && m_score < 3) m_score++;
        if (m_rolls > 0) m_rolls--;
        e.s = 4'(m_score);
        e.r = 4'(m_rolls);
        e.w = (m_score == 3);
        e.l = !e.w && (m_rolls == 0);
        sb.push_back(e);

        roll = 1'b0;
        tick();                              // release edge M: dice latched
        sample(two);
        n_vec++;
        if (oa !== sb[0].a || ob !== sb[0].b) begin
            n_err++;
            $display("FAIL dice: got %0d,%0d want %0d,%0d", oa, ob, sb[0].a, sb[0].b);
        end
        roll = (pulse == 1);
        tick();                              // M+1: CHECK done
        sample(two);
        e = sb.pop_front();
        n_vec++;
        if (om !== e.m || os !== e.s || orl !== e.r) begin
            n_err++;
            $display("FAIL check: got match=%0b score=%0d left=%0d want match=%0b score=%0d left=%0d",
                     om, os, orl, e.m, e.s, e.r);
        end
        roll = (pulse == 2);
        tick();                              // M+2: RESULT done
        sample(two);
        n_vec++;
        if (ow !== e.w || ol !== e.l || obusy !== 1'b0) begin
            n_err++;
            $display("FAIL result: got win=%0b lose=%0b busy=%0b want win=%0b lose=%0b busy=0",
                     ow, ol, obusy, e.w, e.l);
        end
        roll = 1'b0;
        tick();                              // M+3: a press lost in CHECK/RESULT starts nothing
        sample(two);
        n_vec++;
        if (obusy !== 1'b0 || orl !== e.r) begin
            n_err++;
            $display("FAIL settle: got busy=%0b left=%0d want busy=0 left=%0d", obusy, orl, e.r);
        end
        $display("roll dice=%0d,%0d match=%0b score=%0d left=%0d win=%0b lose=%0b",
                 e.a, e.b, e.m, e.s, e.r, e.w, e.l);
    endtask

    task test_reset();
        do_reset(9);
        for (int i = 0; i < 20; i++) tick();
        sample(1'b0);
        n_vec++;
        if (oa !== 3'd1 || ob !== 3'd1 || os !== 4'd0 || orl !== 4'd9 ||
            obusy !== 1'b0 || ow !== 1'b0 || ol !== 1'b0 || om !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got a=%0d b=%0d s=%0d r=%0d busy=%0b w=%0b l=%0b m=%0b want 1 1 0 9 0 0 0 0",
                     oa, ob, os, orl, obusy, ow, ol, om);
        end
        n_vec++;
        if (rolls_left2 !== 4'd2) begin
            n_err++;
            $display("FAIL reset_rolls2: got %0d want 2", rolls_left2);
        end
        $display("reset idle checked");
    endtask

    task test_single_rolls();
        do_reset(9);
        do_roll(1'b0, 0, 6, 0);              // press at edge 1, release at edge 8 -> 2,2 double
        do_reset(9);
        do_roll(1'b0, 0, 1, 0);              // press at edge 1, release at edge 3 -> 3,1
    endtask

    task test_win();
        do_reset(9);
        for (int k = 0; k < 3; k++) do_roll(1'b0, 1, 1, 0);
        roll = 1'b1;
        tick();                              // rise from WIN starts a new game
        sample(1'b0);
        n_vec++;
        if (ow !== 1'b0 || os !== 4'd0 || orl !== 4'd9 || obusy !== 1'b1 || om !== 1'b0) begin
            n_err++;
            $display("FAIL new_game: got w=%0b s=%0d r=%0d busy=%0b m=%0b want 0 0 9 1 0",
                     ow, os, orl, obusy, om);
        end
        roll = 1'b0;
        tick();
        $display("new game after win checked");
    endtask

    task test_lose();
        do_reset(2);
        do_roll(1'b1, 2, 1, 1);
        do_roll(1'b1, 2, 1, 2);
        tick();
        sample(1'b1);
        n_vec++;
        if (ol !== 1'b1 || ow !== 1'b0 || orl !== 4'd0) begin
            n_err++;
            $display("FAIL lose_hold: got lose=%0b win=%0b left=%0d want 1 0 0", ol, ow, orl);
        end
        $display("lose hold checked");
    endtask

    task test_reset_mid();
        bit ok;
        do_reset(9);
        roll = 1'b1;
        tick();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0 && (edges % 6) == ((edges / 6) % 6)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL mid_search: no double found (edges=%0d)", edges);
        end
        roll = 1'b0;
        tick();                              // now in CHECK with a double latched
        rst = 1'b1;
        #1;
        n_vec++;
        if (score !== 4'd0 || rolls_left !== 4'd9 || match !== 1'b0 || busy !== 1'b0 ||
            die_a !== 3'd1 || die_b !== 3'd1) begin
            n_err++;
            $display("FAIL mid_reset: got s=%0d r=%0d m=%0b busy=%0b a=%0d b=%0d want 0 9 0 0 1 1",
                     score, rolls_left, match, busy, die_a, die_b);
        end
        roll = 1'b1;
        tick(); tick();
        rst = 1'b0;
        edges = 0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || score !== 4'd0) begin
            n_err++;
            $display("FAIL post_release: got busy=%0b score=%0d want 0 0", busy, score);
        end
        tick();                              // held roll counts as a rise at edge 1
        n_vec++;
        if (busy !== 1'b1 || match !== 1'b0) begin
            n_err++;
            $display("FAIL held_roll: got busy=%0b match=%0b want 1 0", busy, match);
        end
        roll = 1'b0;
        tick();
        $display("mid-check reset checked");
    endtask

    initial begin
        test_reset();
        test_single_rolls();
        test_win();
        test_lose();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dice_game_ctrl.md
Name: dice_game_ctrl

Overview:
- Sequencer for one dice-game round loop: spins two dice counters while the player holds `roll`, latches the faces on release, compares them for a double, and keeps score and the rolls remaining.
- Declares a win after WIN_SCORE doubles, or a loss when the rolls run out.
- Sits between the roll push-button (already synchronised and debounced upstream) and the seven-segment/LED display logic.

Parameters:
- WIN_SCORE, 3, doubles needed to win; legal range 1..15.
- MAX_ROLLS, 9, rolls allowed per game; legal range 1..15.

Ports:
- sig  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- roll  in  1  roll button level, synchronous to sig; held high = dice spinning.
- die_a  out  3  face of die A, 1..6.
- die_b  out  3  face of die B, 1..6.
- match  out  1  high when the last latched roll was a double.
- score  out  4  doubles scored this game.
- rolls_left  out  4  rolls remaining this game.
- win  out  1  game won; held until the next game starts.
- lose  out  1  game lost; held until the next game starts.
- busy  out  1  high in ROLLING, CHECK and RESULT.

Behaviour:
- Reset (rst=1, asynchronous, dominates everything):
  - state=IDLE, cnt_a=1, cnt_b=1, roll_q=0.
  - die_a=1, die_b=1, match=0, score=0, rolls_left=MAX_ROLLS, win=0, lose=0, busy=0.
- Spin counters:
  - Free-run every edge from reset release, in every state.
  - cnt_a steps 1..6 and wraps 6 to 1.
  - cnt_b steps only on the edge where cnt_a wraps 6 to 1; it also wraps 6 to 1.
  - After N edges: a = (N mod 6)+1, b = ((N div 6) mod 6)+1. The pair covers all 36 combinations in 36 cycles.
  - Counters never hold 0 or 7.
- Edge detect: roll_q <= roll each cycle. rise = roll & ~roll_q.
  - If roll is already high at the first edge after reset, that edge counts as a rise.
- FSM transitions:
  - IDLE: on rise, go to ROLLING and clear match to 0.
  - ROLLING: each edge, die_a<=cnt_a and die_b<=cnt_b (live spin display).
    - When roll is sampled 0, the last such load is the latched value; next state is CHECK.
    - A rise while in ROLLING is impossible and is ignored.
  - CHECK (exactly 1 cycle):
    - match <= (die_a==die_b).
    - score <= score+1 if match, else unchanged.
    - rolls_left <= rolls_left-1.
    - Next state is RESULT.
  - RESULT (1 cycle), using the updated values:
    - If score==WIN_SCORE: set win=1, go to WIN.
    - Else if rolls_left==0: set lose=1, go to LOSE.
    - Else go to IDLE.
    - Win takes priority when the final roll produces the winning double.
  - WIN / LOSE: hold all outputs.
    - On rise: score<=0, rolls_left<=MAX_ROLLS, win<=0, lose<=0, match<=0, then go to ROLLING (the new game's first roll begins immediately).
- Latency:
  - Release sampled at edge M: dice latched at M.
  - match, score and rolls_left valid after edge M+1.
  - win, lose or return to IDLE after edge M+2.
  - roll input is ignored in CHECK and RESULT; a rise there is lost and must be re-pressed.
- Output behaviour:
  - die_a/die_b are stable in every state except ROLLING.
  - busy is combinational from state.
  - score never exceeds WIN_SCORE; rolls_left never underflows.
- Reset mid-operation (any state, including CHECK): immediate return to reset values; no partial score update survives.

Test Plan:
- Reset then idle 20 cycles with roll=0 -> die_a=1, die_b=1, score=0, rolls_left=9, busy=0, win=0, lose=0.
- Release reset; roll=1 sampled at edge 1, roll=0 sampled at edge 8 -> die_a=2, die_b=2. After the next edge: match=1, score=1, rolls_left=8. One edge later: state IDLE.
- roll high at edge 1, low at edge 3 -> die_a=3, die_b=1, match=0, score=0, rolls_left=8.
- Three timed doubles with WIN_SCORE=3 -> win=1 two edges after the third release; rolls_left=6. A further rise clears win, score=0, rolls_left=9, busy=1.
- MAX_ROLLS=2 with two non-doubles -> lose=1 after the second roll; roll pulses in CHECK/RESULT are ignored (no extra roll consumed).
- Assert rst during CHECK after a double -> score=0, rolls_left=MAX_ROLLS, match=0, IDLE on release. Also hold roll=1 through reset release -> ROLLING entered at the first edge.
